hello_rx: RTL and testbench
===========================

# hello_rx

Character-stream receiver and checker for the hello-world print path. It consumes bytes from the printer's character output over a valid/ready handshake and tracks progress through the fixed message "Hello World" (11 ASCII bytes). It pulses on each complete match and keeps a saturating match count. It sits downstream of the printer in the hello bench and in any top level that self-checks printer output.

## Interface
- COUNT_W, 8, width of the match counter
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- char_in  in  8  ASCII byte from the printer
- char_valid  in  1  char_in holds a byte this cycle
- char_ready  out  1  the receiver can accept a byte this cycle
- match  out  1  one-cycle pulse: a complete "Hello World" was received
- mismatch  out  1  one-cycle pulse: a partial match was broken
- idx  out  4  number of message bytes matched so far (0..11)
- match_count  out  COUNT_W  total completed matches, saturating

## Operation
- A byte is accepted on a rising edge where char_valid && char_ready. No other cycle changes idx.
- The expected byte is MSG[idx], where MSG = 48 65 6C 6C 6F 20 57 6F 72 6C 64 ("Hello World").
- Match is case-sensitive and exact. No trailing newline is required.
- States:
  - IDLE: idx==0.
  - MATCH: 0<idx<11.
  - DONE: one cycle, entered when byte 11 is accepted.
- Accepted byte == MSG[idx]:
  - idx<10: idx+1, go to or stay in MATCH.
  - idx==10: idx<=11, go to DONE.
- Accepted byte != MSG[idx]:
  - If idx>0, pulse mismatch.
  - If the byte == 'H' (0x48), idx<=1 and go to MATCH. Otherwise idx<=0 and go to IDLE.
  - 'H' occurs only at MSG[0], so this fallback is a complete prefix-restart.
- DONE:
  - char_ready=0.
  - match=1.
  - match_count increments, holding at 2^COUNT_W-1 when saturated.
  - Next cycle: idx<=0, go to IDLE.
- char_ready is 1 in IDLE and MATCH, 0 in DONE and during reset.
- A byte presented while char_ready=0 is not consumed. The sender holds it, which is legal valid/ready behaviour.

## Timing
- Reset values: char_ready=0 while rst is high, then 1 in the first cycle after rst deasserts. idx=0, match=0, mismatch=0, match_count=0, state IDLE.
- match is registered. It is high exactly in the cycle after the edge that accepted the final 'd' (the DONE cycle).
- mismatch is registered. It is high in the cycle after the offending accept.
- Both pulses last exactly one cycle.
- Throughput: one byte per cycle in IDLE and MATCH. Each match costs one bubble cycle (DONE).
- Back-to-back messages: the first 'H' of the next message is accepted in the cycle after DONE.
- char_valid low: state holds. Gaps of any length are allowed mid-message.
- rst asserted mid-message or in DONE aborts the message. Outputs return to reset values on that edge, and no match or mismatch pulse is produced for the aborted message. match_count clears.
- match and mismatch are never high in the same cycle.

## Structure
- Shared package hello_pkg holds:
  - MSG_LEN = 11.
  - The MSG byte array, which the printer also uses.
  - The state enum {IDLE, MATCH, DONE}.
  - CHAR_H = 8'h48.
- Optional sub-module sat_counter (parameter W, inc, rst, q). It also serves other counters in the lab set.
- Everything else is a single always block for the FSM plus registered outputs.

## Test plan
- Clean message: drive the 11 bytes of "Hello World" with valid high every cycle after reset. match pulses once, 1 cycle after the 'd' accept. match_count=1, mismatch never pulses, char_ready=0 for exactly the DONE cycle.
- Broken prefix with restart: drive "HelHello World". One mismatch pulse occurs after the second 'H' is accepted, idx becomes 1, then one match. match_count=1.
- Wrong case: drive "hello world". No match, no mismatch (idx never leaves 0), idx stays 0.
- Gaps and backpressure: send "Hello World" twice back-to-back with random valid gaps. The second 'H' is held across the DONE cycle (char_ready=0) and accepted next cycle. match_count=2.
- Reset mid-message: after "Hello W" (idx=7), assert rst for 1 cycle. idx=0, match_count=0, no pulses. A following full message gives match_count=1.
- Saturation: with COUNT_W=2, send 5 full messages. match_count sequence is 1,2,3,3,3, and match pulses all 5 times.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared definitions for the hello-world print path: the message bytes,
// the receiver state encoding and the restart character.
package hello_pkg;

  localparam int MSG_LEN = 11;

  localparam logic [7:0] CHAR_H = 8'h48;

  // "Hello World", no trailing newline; the printer walks the same table.
  localparam logic [7:0] MSG [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Out-of-range positions return 0 so a stray index can never look like 'H'.
  function automatic logic [7:0] msg_byte(input logic [3:0] pos);
    logic [7:0] b;
    b = 8'h00;
    if (pos < 4'(MSG_LEN)) b = MSG[pos];
    return b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hello_rx.sv
// Receiver/checker for the "Hello World" character stream: tracks the matched
// prefix, pulses match/mismatch and keeps a saturating count of full matches.
module hello_rx
  import hello_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  output logic               char_ready,
  output logic               match,
  output logic               mismatch,
  output logic [3:0]         idx,
  output logic [COUNT_W-1:0] match_count,
  output logic [1:0]         dbg_state
);

  // Handshake: a byte transfers on a rising edge where char_valid && char_ready.
  // The sender keeps char_in stable while char_ready is low; ready never
  // depends on valid, so there is no combinational loop through the sender.

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       match_q, match_d;
  logic       mismatch_q, mismatch_d;
  logic       count_inc;
  logic       accept;
  logic [7:0] expected;

  assign char_ready = !rst && (state_q != DONE);
  assign accept     = char_valid && char_ready;
  assign expected   = msg_byte(idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    count_inc  = 1'b0;
    case (state_q)
      DONE: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
      default: begin
        if (accept) begin
          if (char_in == expected) begin
            if (idx_q == 4'(MSG_LEN - 1)) begin
              idx_d     = 4'(MSG_LEN);
              state_d   = DONE;
              match_d   = 1'b1;
              count_inc = 1'b1;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = MATCH;
            end
          end else begin
            mismatch_d = (idx_q != 4'd0);
            // 'H' appears only at the head of the message, so restarting at
            // idx 1 is the complete prefix-restart.
            if (char_in == CHAR_H) begin
              idx_d   = 4'd1;
              state_d = MATCH;
            end else begin
              idx_d   = 4'd0;
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  // Counting on the accepting edge makes the new total visible in the DONE cycle.
  sat_counter #(.W(COUNT_W)) u_count (
    .clk (clk),
    .rst (rst),
    .inc (count_inc),
    .q   (match_count)
  );

  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign idx       = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hello_rx.sv
// Bench for hello_rx: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared against a string-prefix reference model.
module tb_hello_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;

  logic       char_ready, match, mismatch;
  logic [3:0] idx;
  logic [7:0] match_count;
  logic [1:0] st1;
  logic       char_ready2, match2, mismatch2;
  logic [3:0] idx2;
  logic [1:0] match_count2;
  logic [1:0] st2;

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  string msg = "Hello World";

  // clock / reset
  always #5 clk = ~clk;

  hello_rx #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .match(match), .mismatch(mismatch), .idx(idx),
    .match_count(match_count), .dbg_state(st1)
  );

  hello_rx #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready2), .match(match2), .mismatch(mismatch2), .idx(idx2),
    .match_count(match_count2), .dbg_state(st2)
  );

  // reference model: m_buf is the longest message prefix received so far
  string m_buf = "";
  string cand;
  bit    m_done = 1'b0;
  bit    m_mm = 1'b0;
  int    m_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_buf   <= "";
      m_done  <= 1'b0;
      m_mm    <= 1'b0;
      m_count <= 0;
    end else begin
      m_mm <= 1'b0;
      if (m_done) begin
        m_done <= 1'b0;
      end else if (char_valid) begin
        cand = $sformatf("%s%c", m_buf, char_in);
        if (cand == msg.substr(0, cand.len() - 1)) begin
          if (cand.len() == msg.len()) begin
            m_buf   <= "";
            m_done  <= 1'b1;
            m_count <= m_count + 1;
          end else begin
            m_buf <= cand;
          end
        end else begin
          m_mm  <= (m_buf.len() != 0);
          m_buf <= (char_in == 8'h48) ? "H" : "";
        end
      end
    end
  end

  // scoreboard: every cycle, both instances against the model
  int tot_match = 0, tot_mm = 0, tot_rdy_low = 0;

  always @(posedge clk) begin
    int exp_idx, exp_c1, exp_c2;
    bit exp_rdy;
    #3;
    if (chk_en) begin
      exp_idx = m_done ? 11 : m_buf.len();
      exp_rdy = !rst && !m_done;
      exp_c1  = (m_count > 255) ? 255 : m_count;
      exp_c2  = (m_count > 3) ? 3 : m_count;
      n_vec++;
      if ({idx, match, mismatch, char_ready} !== {4'(exp_idx), m_done, m_mm, exp_rdy}) begin
        n_err++;
        $display("FAIL lockstep8 t=%0t idx/match/mm/rdy got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 $time, idx, match, mismatch, char_ready, exp_idx, m_done, m_mm, exp_rdy);
      end
      n_vec++;
      if ({idx2, match2, mismatch2, char_ready2} !== {4'(exp_idx), m_done, m_mm, exp_rdy}) begin
        n_err++;
        $display("FAIL lockstep2 t=%0t idx/match/mm/rdy got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 $time, idx2, match2, mismatch2, char_ready2, exp_idx, m_done, m_mm, exp_rdy);
      end
      n_vec++;
      if (match_count !== 8'(exp_c1) || match_count2 !== 2'(exp_c2)) begin
        n_err++;
        $display("FAIL count t=%0t got %0d/%0d want %0d/%0d",
                 $time, match_count, match_count2, exp_c1, exp_c2);
      end
      if (match) tot_match++;
      if (mismatch) tot_mm++;
      if (!rst && !char_ready) tot_rdy_low++;
    end
  end

  // driver tasks
  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      int  waited;
      bit  rdy;
      @(negedge clk);
      char_in    = s.getc(i);
      char_valid = 1'b1;
      waited = 0;
      forever begin
        rdy = char_ready;
        @(posedge clk);
        if (rdy) break;
        waited++;
        if (waited > 20) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout byte %0d of '%s' got no ready want ready", i, s);
          break;
        end
        @(negedge clk);
      end
      if (gap_max > 0 && i != s.len() - 1) begin
        int g;
        g = $urandom_range(0, gap_max);
        repeat (g) begin
          @(negedge clk);
          char_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      char_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    char_valid = 1'b0;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({idx, match, mismatch, char_ready, match_count} !== {4'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_values got idx=%0d m=%b mm=%b rdy=%b cnt=%0d want 0/0/0/0/0",
               idx, match, mismatch, char_ready, match_count);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    n_vec++;
    if (char_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset got %b want 1", char_ready);
    end
  endtask

  task automatic test_clean();
    int sm, smm, srl;
    do_reset(2);
    sm = tot_match; smm = tot_mm; srl = tot_rdy_low;
    send_str("Hello World", 0);
    #1;
    n_vec++;
    if ({match, char_ready, match_count, idx} !== {1'b1, 1'b0, 8'd1, 4'd11}) begin
      n_err++;
      $display("FAIL clean_done got m=%b rdy=%b cnt=%0d idx=%0d want 1/0/1/11",
               match, char_ready, match_count, idx);
    end
    idle(4);
    #1;
    n_vec++;
    if ((tot_match - sm) != 1 || (tot_mm - smm) != 0 || (tot_rdy_low - srl) != 1 || idx !== 4'd0) begin
      n_err++;
      $display("FAIL clean_totals got m=%0d mm=%0d rdylow=%0d idx=%0d want 1/0/1/0",
               tot_match - sm, tot_mm - smm, tot_rdy_low - srl, idx);
    end
  endtask

  task automatic test_broken_prefix();
    int sm, smm;
    do_reset(1);
    sm = tot_match; smm = tot_mm;
    send_str("Hel", 0);
    send_str("H", 0);
    #1;
    n_vec++;
    if (mismatch !== 1'b1 || idx !== 4'd1) begin
      n_err++;
      $display("FAIL restart got mm=%b idx=%0d want 1/1", mismatch, idx);
    end
    send_str("ello World", 0);
    #1;
    n_vec++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL restart_match got m=%b cnt=%0d want 1/1", match, match_count);
    end
    idle(3);
    n_vec++;
    if ((tot_match - sm) != 1 || (tot_mm - smm) != 1) begin
      n_err++;
      $display("FAIL restart_totals got m=%0d mm=%0d want 1/1", tot_match - sm, tot_mm - smm);
    end
  endtask

  task automatic test_wrong_case();
    int sm, smm;
    string s;
    s = "hello world";
    do_reset(1);
    sm = tot_match; smm = tot_mm;
    for (int i = 0; i < s.len(); i++) begin
      send_str(s.substr(i, i), 0);
      #1;
      n_vec++;
      if (idx !== 4'd0) begin
        n_err++;
        $display("FAIL wrong_case_idx byte %0d got %0d want 0", i, idx);
      end
    end
    idle(3);
    n_vec++;
    if ((tot_match - sm) != 0 || (tot_mm - smm) != 0) begin
      n_err++;
      $display("FAIL wrong_case_pulses got m=%0d mm=%0d want 0/0", tot_match - sm, tot_mm - smm);
    end
  endtask

  task automatic test_back_to_back();
    int sm, srl;
    do_reset(1);
    sm = tot_match; srl = tot_rdy_low;
    send_str("Hello World", 3);
    #1;
    n_vec++;
    if (match !== 1'b1 || char_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first got m=%b rdy=%b want 1/0", match, char_ready);
    end
    send_str("Hello World", 3);
    #1;
    n_vec++;
    if (match !== 1'b1 || match_count !== 8'd2) begin
      n_err++;
      $display("FAIL b2b_second got m=%b cnt=%0d want 1/2", match, match_count);
    end
    idle(3);
    n_vec++;
    if ((tot_match - sm) != 2 || (tot_rdy_low - srl) != 2) begin
      n_err++;
      $display("FAIL b2b_totals got m=%0d rdylow=%0d want 2/2", tot_match - sm, tot_rdy_low - srl);
    end
  endtask

  task automatic test_reset_mid();
    int sm, smm;
    do_reset(1);
    send_str("Hello World", 0);
    send_str("Hello W", 2);
    #1;
    n_vec++;
    if (idx !== 4'd7 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL mid_progress got idx=%0d cnt=%0d want 7/1", idx, match_count);
    end
    sm = tot_match; smm = tot_mm;
    do_reset(1);
    #1;
    n_vec++;
    if ({idx, match, mismatch, match_count} !== {4'd0, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL mid_reset got idx=%0d m=%b mm=%b cnt=%0d want 0/0/0/0",
               idx, match, mismatch, match_count);
    end
    idle(2);
    n_vec++;
    if ((tot_match - sm) != 0 || (tot_mm - smm) != 0) begin
      n_err++;
      $display("FAIL mid_pulses got m=%0d mm=%0d want 0/0", tot_match - sm, tot_mm - smm);
    end
    send_str("Hello World", 1);
    #1;
    n_vec++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL mid_after got m=%b cnt=%0d want 1/1", match, match_count);
    end
    idle(2);
  endtask

  task automatic test_saturation();
    int exp_c2 [5] = '{1, 2, 3, 3, 3};
    int sm;
    do_reset(1);
    sm = tot_match;
    for (int k = 0; k < 5; k++) begin
      send_str("Hello World", (k % 2) * 2);
      #1;
      n_vec++;
      if (match2 !== 1'b1 || match_count2 !== 2'(exp_c2[k]) || match_count !== 8'(k + 1)) begin
        n_err++;
        $display("FAIL saturation msg %0d got m=%b cnt2=%0d cnt8=%0d want 1/%0d/%0d",
                 k, match2, match_count2, match_count, exp_c2[k], k + 1);
      end
    end
    idle(3);
    n_vec++;
    if ((tot_match - sm) != 5) begin
      n_err++;
      $display("FAIL saturation_pulses got %0d want 5", tot_match - sm);
    end
  endtask

  task automatic test_random();
    string s;
    string alpha;
    alpha = "HelloWrd Hx";
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      s = "";
      if ($urandom_range(0, 2) == 0) begin
        s = msg;
      end else begin
        repeat ($urandom_range(1, 8)) begin
          int p;
          p = $urandom_range(0, alpha.len() - 1);
          s = {s, alpha.substr(p, p)};
        end
      end
      send_str(s, $urandom_range(0, 2));
    end
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // final report
  initial begin
    test_reset();
    test_clean();
    test_broken_prefix();
    test_wrong_case();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
